// File: rtl/cs_result_fifo.sv
// Result FIFO behind the 9-tap window averager: discards warm-up results,
// buffers the rest with show-ahead output, and counts overrun drops.
module cs_result_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 16,
  parameter int WARMUP = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        y_in,
  input  logic                     y_valid,
  input  logic                     flush,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {WARM, RUN} state_t;

  localparam state_t     INIT_STATE = (WARMUP == 0) ? RUN : WARM;
  localparam logic [7:0] WARM_LAST  = 8'(WARMUP - 1);

  state_t              state, state_next;
  logic [7:0]          warm_cnt, warm_next;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                push, pop, wr_en, drop;

  assign dout_valid = (count != '0);
  assign full       = (count == CW'(DEPTH));
  assign dout       = dout_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= INIT_STATE;
      warm_cnt <= '0;
    end else begin
      state    <= state_next;
      warm_cnt <= warm_next;
    end
  end

  always_comb begin
    state_next = state;
    warm_next  = warm_cnt;
    push       = 1'b0;
    if (flush) begin
      state_next = INIT_STATE;
      warm_next  = '0;
    end else begin
      case (state)
        WARM: if (y_valid) begin
          warm_next = 8'(warm_cnt + 8'd1);
          if (warm_cnt == WARM_LAST) state_next = RUN;
        end
        RUN: push = y_valid;
        default: ;
      endcase
    end
    pop   = dout_valid & dout_ready & ~flush;
    // A push into a full FIFO still lands when the head leaves the same cycle.
    wr_en = push & (~full | pop);
    drop  = push & full & ~pop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= AW'(wr_ptr + 1'b1);
      if (pop)   rd_ptr <= AW'(rd_ptr + 1'b1);
      case ({wr_en, pop})
        2'b10:   count <= CW'(count + 1'b1);
        2'b01:   count <= CW'(count - 1'b1);
        default: ;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= 8'(drop_cnt + 8'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= y_in;
  end

endmodule

// File: tb/tb_cs_result_fifo.sv
// Directed bench for cs_result_fifo: warm-up discard, drain order, overrun,
// full-FIFO pass-through, flush, async reset, and a WARMUP=0 build.
module tb_cs_result_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] y_in = '0;
  logic       y_valid = 1'b0;
  logic       flush = 1'b0;
  logic       dout_ready = 1'b0;
  logic [9:0] dout;
  logic       dout_valid;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic [7:0] drop_cnt;

  logic [9:0] z_in = '0;
  logic       z_valid = 1'b0;
  logic [9:0] z_dout;
  logic       z_dout_valid;
  logic [4:0] z_count;
  logic       z_full;
  logic       z_overflow;
  logic [7:0] z_drop_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cs_result_fifo #(.DATA_W(10), .DEPTH(16), .WARMUP(8)) dut (
    .clk(clk), .reset(reset), .y_in(y_in), .y_valid(y_valid), .flush(flush),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .count(count), .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  cs_result_fifo #(.DATA_W(10), .DEPTH(16), .WARMUP(0)) dut0 (
    .clk(clk), .reset(reset), .y_in(z_in), .y_valid(z_valid), .flush(1'b0),
    .dout(z_dout), .dout_valid(z_dout_valid), .dout_ready(1'b0),
    .count(z_count), .full(z_full), .overflow(z_overflow), .drop_cnt(z_drop_cnt)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    cyc(); cyc();
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop", drop_cnt, 0);
    reset = 1'b0;
    cyc();

    // WARMUP=0 build stores the very first sample
    z_valid = 1'b1; z_in = 10'h3FF;
    cyc();
    z_valid = 1'b0;
    chk("w0_dout", z_dout, 10'h3FF);
    chk("w0_valid", z_dout_valid, 1);
    chk("w0_count", z_count, 1);

    // warm-up: 100..107 discarded, 108..111 stored
    y_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      y_in = 10'(100 + i);
      cyc();
      if (i == 7) chk("warm_8th_count", count, 0);
      if (i == 8) chk("warm_9th_dout", dout, 108);
    end
    y_valid = 1'b0;
    chk("warm_count", count, 4);
    chk("warm_dout", dout, 108);
    chk("warm_valid", dout_valid, 1);
    chk("warm_overflow", overflow, 0);

    // drain 108..111
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain1_dout", dout, 108 + i);
      cyc();
    end
    dout_ready = 1'b0;
    chk("drain1_valid", dout_valid, 0);
    chk("drain1_dout0", dout, 0);
    chk("drain1_count", count, 0);

    // overrun: 20 pushes into 16 entries
    y_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      y_in = 10'(i);
      cyc();
    end
    chk("ovr_count", count, 16);
    chk("ovr_full", full, 1);
    chk("ovr_overflow", overflow, 1);
    chk("ovr_drop", drop_cnt, 4);
    chk("ovr_head", dout, 0);

    // full FIFO with simultaneous push/pop
    dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      y_in = 10'(200 + i);
      chk("pp_dout", dout, i);
      cyc();
      chk("pp_count", count, 16);
    end
    chk("pp_drop", drop_cnt, 4);

    // drain: 5..15 then 200..204
    y_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("drain2_dout", dout, (i < 11) ? 5 + i : 200 + i - 11);
      cyc();
    end
    dout_ready = 1'b0;
    chk("drain2_count", count, 0);
    chk("drain2_valid", dout_valid, 0);

    // flush with 6 entries and overflow set
    y_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      y_in = 10'(250 + i);
      cyc();
    end
    chk("pre_flush_count", count, 6);
    chk("pre_flush_ovf", overflow, 1);
    flush = 1'b1; dout_ready = 1'b1; y_in = 10'd999;
    cyc();
    flush = 1'b0; dout_ready = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_ovf", overflow, 0);
    chk("flush_drop", drop_cnt, 0);
    chk("flush_valid", dout_valid, 0);
    for (int i = 0; i < 9; i++) begin
      y_in = 10'(300 + i);
      cyc();
      if (i == 7) chk("flush_warm_count", count, 0);
    end
    chk("flush_9th_count", count, 1);
    chk("flush_9th_dout", dout, 308);

    // async reset mid-stream
    dout_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      y_in = 10'(400 + i);
      cyc();
    end
    chk("stream_count", count, 1);
    chk("stream_dout", dout, 402);
    #3 reset = 1'b1;
    #1;
    chk("arst_dout", dout, 0);
    chk("arst_valid", dout_valid, 0);
    chk("arst_count", count, 0);
    y_valid = 1'b0;
    cyc();
    reset = 1'b0;
    y_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      y_in = 10'(500 + i);
      cyc();
      if (i == 7) chk("arst_warm_count", count, 0);
    end
    y_valid = 1'b0; dout_ready = 1'b0;
    chk("arst_9th_count", count, 1);
    chk("arst_9th_dout", dout, 508);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
